piso_serializer: RTL and testbench
==================================

# piso_serializer

Parametrised parallel-in/serial-out shift register with a valid/ready load port and a valid/ready serial port. It generalises the fixed 4-bit and 8-bit PISO chains to any WIDTH, adds a per-frame bit-order select, sink backpressure, last-bit marking, and gap-free back-to-back reloads. It sits between a parallel word producer and a bit-serial link or transmitter.

## Interface
- WIDTH, 8, frame length in bits; legal range ≥ 2
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- load_valid  input  1  producer offers a word
- load_ready  output  1  block accepts a word this cycle
- load_data  input  WIDTH  parallel word
- load_msb_first  input  1  bit order for this word, sampled with load_data: 1 = MSB first, 0 = LSB first
- so_valid  output  1  so_data carries a valid bit
- so_ready  input  1  sink accepts the bit
- so_data  output  1  serial bit
- so_last  output  1  final bit of the frame
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after a frame's last bit is accepted

## Operation
- States: IDLE, SHIFT.
- Load handshake: load_valid && load_ready. Capture load_data into shreg, bit-reversed when load_msb_first = 1, so shreg[0] is always the next bit. Set cnt = WIDTH-1 and enter SHIFT.
- Output handshake: so_valid && so_ready.
- IDLE: load_ready = 1, so_valid = 0, so_data = 0, so_last = 0, busy = 0.
- SHIFT: so_valid = 1, busy = 1, so_data = shreg[0], so_last = (cnt == 0).
- Non-last bit accepted: shreg shifts right with zero fill; cnt decrements.
- so_ready = 0: shreg, cnt, so_data and so_last hold. No bit is lost or repeated.
- Last bit accepted (cnt == 0 && so_ready):
  - If load_valid is high, load the new word and stay in SHIFT.
  - Otherwise go to IDLE.
  - In either case, frame_done = 1 in the next cycle.
- load_ready = (state == IDLE) || (state == SHIFT && cnt == 0 && so_ready). This is a combinational path from so_ready to load_ready, and it is documented as such.
- load_ready is forced to 0 while reset is low.
- load_valid asserted in SHIFT before the last beat is ignored. The producer holds it.
- Reset mid-frame: all state clears immediately, the frame is discarded, and no frame_done is issued.

## Timing
- Reset values: state = IDLE, shreg = 0, cnt = 0, so_valid = 0, so_data = 0, so_last = 0, busy = 0, frame_done = 0, load_ready = 0 (then 1 from the first cycle after release).
- Load accepted at edge N → first bit on so_data in cycle N+1.
- With so_ready held high, a frame occupies exactly WIDTH cycles. so_last is high in the WIDTH-th cycle; frame_done is high in cycle WIDTH+1 for one cycle.
- Each so_ready-low cycle stretches the frame by one cycle.
- Back-to-back loads give 100% serial occupancy, with zero idle cycles between frames.
- frame_done for frame k can coincide with the first bit of frame k+1.

## Structure
- Package piso_pkg holds:
  - the state typedef (enum IDLE, SHIFT);
  - a bit_reverse function parametrised on WIDTH.
- Sub-module piso_bit_counter (CNT_W-bit down-counter):
  - inputs: load, decrement enable;
  - output: zero flag.
- The top module holds shreg, the FSM, handshake logic and the frame_done register.
- All flops use the async active-low reset.

## Test plan
WIDTH = 8 unless noted.
- Reset: hold reset low with stimulus active → all outputs 0, including load_ready. Release → load_ready = 1 next cycle.
- LSB-first: load 8'hC1 with load_msb_first = 0, so_ready = 1 → so_data = 1,0,0,0,0,0,1,1. so_last in bit 8; frame_done in the following cycle only.
- MSB-first: load 8'hC1 with load_msb_first = 1 → so_data = 1,1,0,0,0,0,0,1.
- Backpressure: drop so_ready for 3 cycles after bit 3 of 8'h0F (LSB-first) → so_data holds at 1, no bit lost, frame spans 11 cycles, sequence = 1,1,1,1,0,0,0,0.
- Back-to-back: load 8'hC1 then 8'h0F, load_valid held, both LSB-first → load_ready high during bit 8 of frame 1. 16 contiguous bits: 1,0,0,0,0,0,1,1,1,1,1,1,0,0,0,0. Two frame_done pulses, 8 cycles apart.
- Reset mid-frame: assert reset after bit 3 → immediate clear, no frame_done. A new load of 8'h0F after release serialises correctly. Repeat with WIDTH = 5 and WIDTH = 16.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Widest frame the reversal helper handles; wider frames need this raised.
  localparam int unsigned REV_MAX_W = 64;

  // Reverses the low 'width' bits of data; bits above 'width' come back zero.
  function automatic logic [REV_MAX_W-1:0] bit_reverse(
    input logic [REV_MAX_W-1:0] data,
    input int unsigned          width
  );
    logic [REV_MAX_W-1:0] rev;
    rev = '0;
    for (int unsigned i = 0; i < REV_MAX_W; i++) begin
      if (i < width) rev[i] = data[width-1-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Down-counter tracking the bits left in the current frame.
module piso_bit_counter #(
  parameter int unsigned      CNT_W    = 3,
  parameter logic [CNT_W-1:0] LOAD_VAL = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; the async active-low reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with valid/ready on both sides.
// load_ready depends combinationally on so_ready so a new word can be
// accepted on the same edge that the last bit of the current frame leaves.
module piso_serializer
  import piso_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_msb_first,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             so_data,
  output logic             so_last,
  output logic             busy,
  output logic             frame_done
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shreg_q;
  logic [WIDTH-1:0]     load_word;
  logic [REV_MAX_W-1:0] rev_full;
  logic                 cnt_zero;
  logic                 load_fire;
  logic                 so_fire;
  logic                 last_fire;
  logic                 frame_done_q;

  // Handshakes
  assign load_ready = reset &&
                      ((state_q == IDLE) ||
                       ((state_q == SHIFT) && cnt_zero && so_ready));
  assign load_fire  = load_valid && load_ready;
  assign so_fire    = (state_q == SHIFT) && so_ready;
  assign last_fire  = so_fire && cnt_zero;

  // shreg[0] is always the next bit out, so MSB-first words are stored reversed.
  assign rev_full  = bit_reverse(REV_MAX_W'(load_data), WIDTH);
  assign load_word = load_msb_first ? rev_full[WIDTH-1:0] : load_data;

  piso_bit_counter #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (CNT_W'(WIDTH - 1))
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .load  (load_fire),
    .dec   (so_fire && !cnt_zero),
    .zero  (cnt_zero)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (load_fire) state_d = SHIFT;
      SHIFT: if (last_fire) state_d = load_fire ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    so_valid = 1'b0;
    so_data  = 1'b0;
    so_last  = 1'b0;
    busy     = 1'b0;
    if (state_q == SHIFT) begin
      so_valid = 1'b1;
      so_data  = shreg_q[0];
      so_last  = cnt_zero;
      busy     = 1'b1;
    end
  end

  // Shift register: a reload wins over the final shift of the previous frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
    end else if (load_fire) begin
      shreg_q <= load_word;
    end else if (so_fire) begin
      shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_done_q <= 1'b0;
    else        frame_done_q <= last_fire;
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: stimulus queues hand-computed bits, a negedge monitor pops and compares.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  // Instance 0: WIDTH=8, 1: WIDTH=5, 2: WIDTH=16
  logic lv[3], lr[3], msb[3], sv[3], sr[3], sd[3], sl[3], bz[3], fd[3];
  logic [7:0]  ld8;
  logic [4:0]  ld5;
  logic [15:0] ld16;

  int checks = 0;
  int errors = 0;

  logic [1:0] q0[$], q1[$], q2[$];   // {data, last}
  int         fire_t[$];             // cycles with an accepted bit, instance 0
  int         done_t[$];             // cycles with frame_done, instance 0
  int         done_cnt[3];
  bit         done_exp[3];
  bit         stall_prev[3];
  logic [1:0] held[3];
  logic       ready_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_serializer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(lr[0]),
    .load_data(ld8), .load_msb_first(msb[0]), .so_valid(sv[0]), .so_ready(sr[0]),
    .so_data(sd[0]), .so_last(sl[0]), .busy(bz[0]), .frame_done(fd[0]));

  piso_serializer #(.WIDTH(5)) u_dut5 (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(lr[1]),
    .load_data(ld5), .load_msb_first(msb[1]), .so_valid(sv[1]), .so_ready(sr[1]),
    .so_data(sd[1]), .so_last(sl[1]), .busy(bz[1]), .frame_done(fd[1]));

  piso_serializer #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .load_valid(lv[2]), .load_ready(lr[2]),
    .load_data(ld16), .load_msb_first(msb[2]), .so_valid(sv[2]), .so_ready(sr[2]),
    .so_data(sd[2]), .so_last(sl[2]), .busy(bz[2]), .frame_done(fd[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_bits(input int d, input string s);
    logic [1:0] e;
    for (int i = 0; i < s.len(); i++) begin
      e = {(s[i] == "1"), (i == s.len() - 1)};
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic pop_exp(input int d, output logic [1:0] e);
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic flush(input int d);
    case (d)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [1:0] e;
    for (int d = 0; d < 3; d++) begin
      if (!reset) begin
        check($sformatf("reset_outputs_%0d", d),
              {26'd0, lr[d], sv[d], sd[d], sl[d], bz[d], fd[d]}, 32'd0);
        done_exp[d]   = 1'b0;
        stall_prev[d] = 1'b0;
        flush(d);
      end else begin
        check($sformatf("frame_done_%0d", d), fd[d], done_exp[d]);
        if (fd[d]) done_cnt[d]++;
        if (d == 0 && fd[0]) done_t.push_back(cyc);
        if (stall_prev[d] && sv[d])
          check($sformatf("stall_hold_%0d", d), {sd[d], sl[d]}, held[d]);
        if (sv[d] && sr[d]) begin
          check($sformatf("bit_expected_%0d", d), (qsize(d) > 0), 1);
          if (qsize(d) > 0) begin
            pop_exp(d, e);
            check($sformatf("so_data_last_%0d", d), {sd[d], sl[d]}, e);
          end
          if (d == 0) fire_t.push_back(cyc);
        end
        done_exp[d]   = sv[d] && sr[d] && sl[d];
        stall_prev[d] = sv[d] && !sr[d];
        held[d]       = {sd[d], sl[d]};
      end
    end
  end

  task automatic wait_ready(input int d);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (lr[d]) return;
    end
    check($sformatf("load_ready_timeout_%0d", d), lr[d], 1);
  endtask

  task automatic load8(input logic [7:0] data, input bit m, input bit keep, output int acc_t);
    @(posedge clk);
    #1;
    ld8 = data; msb[0] = m; lv[0] = 1'b1;
    wait_ready(0);
    ready_last = sl[0];
    @(posedge clk);
    #1;
    if (!keep) lv[0] = 1'b0;
    acc_t = cyc;
  endtask

  task automatic wait_drain(input int d);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (qsize(d) == 0 && !bz[d]) break;
    end
    check($sformatf("drain_%0d", d), qsize(d), 0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int acc, acc2;
    reset = 1'b0;
    ld8 = 8'hFF; ld5 = 5'h1F; ld16 = 16'hFFFF;
    for (int d = 0; d < 3; d++) begin
      lv[d] = 1'b1; msb[d] = 1'b0; sr[d] = 1'b1; done_cnt[d] = 0;
    end

    // Reset with stimulus active; monitor checks all outputs are zero.
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) lv[d] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("ready_after_release_%0d", d), lr[d], 1);

    // LSB-first 8'hC1
    fire_t.delete(); done_t.delete();
    push_bits(0, "10000011");
    load8(8'hC1, 1'b0, 1'b0, acc);
    wait_drain(0);
    check("lsb_bits", fire_t.size(), 8);
    if (fire_t.size() == 8) check("lsb_first_bit_cycle", fire_t[0], acc);
    check("lsb_done_count", done_t.size(), 1);
    if (done_t.size() == 1) check("lsb_done_cycle", done_t[0] - acc, 8);

    // MSB-first 8'hC1
    fire_t.delete(); done_t.delete();
    push_bits(0, "11000001");
    load8(8'hC1, 1'b1, 1'b0, acc);
    wait_drain(0);
    check("msb_done_count", done_t.size(), 1);

    // Backpressure: 3 stall cycles after bit 3 of 8'h0F
    fire_t.delete(); done_t.delete();
    push_bits(0, "11110000");
    load8(8'h0F, 1'b0, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1 sr[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 sr[0] = 1'b1;
    wait_drain(0);
    check("bp_bits", fire_t.size(), 8);
    if (fire_t.size() == 8) check("bp_span", fire_t[7] - fire_t[0], 10);
    check("bp_done_count", done_t.size(), 1);
    if (done_t.size() == 1) check("bp_done_cycle", done_t[0] - acc, 11);

    // Back-to-back 8'hC1 then 8'h0F with load_valid held
    fire_t.delete(); done_t.delete();
    push_bits(0, "10000011");
    push_bits(0, "11110000");
    load8(8'hC1, 1'b0, 1'b1, acc);
    load8(8'h0F, 1'b0, 1'b0, acc2);
    check("b2b_ready_on_last_bit", ready_last, 1);
    check("b2b_load_gap", acc2 - acc, 8);
    wait_drain(0);
    check("b2b_bits", fire_t.size(), 16);
    if (fire_t.size() == 16) check("b2b_contiguous", fire_t[15] - fire_t[0], 15);
    check("b2b_done_count", done_t.size(), 2);
    if (done_t.size() == 2) check("b2b_done_spacing", done_t[1] - done_t[0], 8);

    // Reset mid-frame on all three widths, then a clean 0x0F frame
    for (int d = 0; d < 3; d++) done_cnt[d] = 0;
    push_bits(0, "11110000");
    push_bits(1, "11110");
    push_bits(2, "1111000000000000");
    @(posedge clk);
    #1;
    ld8 = 8'h0F; ld5 = 5'h0F; ld16 = 16'h000F;
    for (int d = 0; d < 3; d++) lv[d] = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) lv[d] = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("mid_rst_no_done_%0d", d), done_cnt[d], 0);
      check($sformatf("mid_rst_ready_%0d", d), lr[d], 1);
    end
    push_bits(0, "11110000");
    push_bits(1, "11110");
    push_bits(2, "1111000000000000");
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) lv[d] = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) lv[d] = 1'b0;
    for (int d = 0; d < 3; d++) wait_drain(d);
    for (int d = 0; d < 3; d++) check($sformatf("after_rst_done_%0d", d), done_cnt[d], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
